// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared defaults and level-count helper for the pipelined mux tree
package mux_pkg;

  localparam int MUX_DEFAULT_WIDTH = 8;
  localparam int MUX_DEFAULT_N     = 8;

  function automatic int mux_levels(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mux_2to1_reg.sv
// rtl/mux_2to1_reg.sv - one registered 2:1 tree stage with load enable
module mux_2to1_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign q_d = sel_i ? b_i : a_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mux_nto1_pipelined.sv
// rtl/mux_nto1_pipelined.sv - registered N:1 mux tree with valid/ready handshake
// Optional scan-counter select enabled by macro MUX_SCAN_EN.
module mux_nto1_pipelined
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH,
  parameter int N     = MUX_DEFAULT_N
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef MUX_SCAN_EN
  input  logic                        scan_en,
`endif
  input  logic [N*WIDTH-1:0]          in_data,
  input  logic [mux_levels(N)-1:0]    in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [mux_levels(N)-1:0]    out_sel,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int SEL_W = mux_levels(N);

  logic                 adv;
  logic [SEL_W-1:0]     sel0;
  logic [SEL_W-1:0]     valid_q;
  logic [SEL_W-1:0]     idx_q [SEL_W];

  // Heap-ordered tree nodes: node 0 is the root, leaves N-1..2N-2 are the inputs.
  logic [(2*N-1)*WIDTH-1:0] node;

  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = valid_q[SEL_W-1];
  assign out_sel   = idx_q[SEL_W-1];
  assign out_data  = node[WIDTH-1:0];

`ifdef MUX_SCAN_EN
  logic [SEL_W-1:0] scan_q;
  logic [SEL_W-1:0] scan_d;

  always_comb begin
    scan_d = scan_q;
    if (scan_en && in_valid && adv) begin
      scan_d = scan_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
    end else begin
      scan_q <= scan_d;
    end
  end

  assign sel0 = scan_en ? scan_q : in_sel;
`else
  assign sel0 = in_sel;
`endif

  // The full index travels with each beat; level j reads its own bit from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int j = 0; j < SEL_W; j++) begin
        idx_q[j] <= '0;
      end
    end else if (adv) begin
      valid_q[0] <= in_valid;
      idx_q[0]   <= sel0;
      for (int j = 1; j < SEL_W; j++) begin
        valid_q[j] <= valid_q[j-1];
        idx_q[j]   <= idx_q[j-1];
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_leaf
    assign node[(N-1+k)*WIDTH +: WIDTH] = in_data[k*WIDTH +: WIDTH];
  end

  for (genvar j = 0; j < SEL_W; j++) begin : g_lvl
    localparam int D = SEL_W - 1 - j;
    logic lvl_sel;

    if (j == 0) begin : g_sel_in
      assign lvl_sel = sel0[0];
    end else begin : g_sel_pipe
      assign lvl_sel = idx_q[j-1][j];
    end

    for (genvar k = 0; k < (N >> (j + 1)); k++) begin : g_node
      localparam int I = (1 << D) - 1 + k;

      mux_2to1_reg #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (adv),
        .sel_i (lvl_sel),
        .a_i   (node[(2*I+1)*WIDTH +: WIDTH]),
        .b_i   (node[(2*I+2)*WIDTH +: WIDTH]),
        .q_o   (node[I*WIDTH +: WIDTH])
      );
    end
  end

endmodule

// File: tb/tb_mux_nto1_pipelined.sv
// tb/tb_mux_nto1_pipelined.sv - directed self-checking bench for the pipelined mux tree
module tb_mux_nto1_pipelined;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_data;
  logic [2:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_valid;
  logic        out_ready = 1'b1;
`ifdef MUX_SCAN_EN
  logic        scan_en = 1'b0;
  logic        scan_en2 = 1'b0;
`endif

  logic [1:0]  in_data2 = 2'b10;
  logic [0:0]  in_sel2 = '0;
  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [0:0]  out_data2;
  logic [0:0]  out_sel2;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mux_nto1_pipelined #(.WIDTH(8), .N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MUX_SCAN_EN
    .scan_en   (scan_en),
`endif
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_nto1_pipelined #(.WIDTH(1), .N(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MUX_SCAN_EN
    .scan_en   (scan_en2),
`endif
    .in_data   (in_data2),
    .in_sel    (in_sel2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .out_data  (out_data2),
    .out_sel   (out_sel2),
    .out_valid (out_valid2),
    .out_ready (out_ready2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({out_valid, out_data, out_sel, in_ready} !== {1'b0, 8'h00, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state got v=%b d=%h s=%0d r=%b exp v=0 d=00 s=0 r=1",
               out_valid, out_data, out_sel, in_ready);
    end
    total++;
    if ({out_valid2, out_data2, out_sel2, in_ready2} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_state_n2 got %b exp 0001",
               {out_valid2, out_data2, out_sel2, in_ready2});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 11; t++) begin
      in_valid = (t < 8);
      in_sel = 3'(t);
      step();
      if (t < 2 || t >= 10) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL b2b_idle t=%0d got v=%b exp v=0", t, out_valid);
        end
      end else begin
        total++;
        if ({out_valid, out_data, out_sel} !== {1'b1, 8'(8'h10 + t - 2), 3'(t - 2)}) begin
          bad++;
          $display("FAIL b2b_beat t=%0d got v=%b d=%h s=%0d exp v=1 d=%h s=%0d",
                   t, out_valid, out_data, out_sel, 8'(8'h10 + t - 2), t - 2);
        end
      end
    end
    flush();
  endtask

  task automatic test_stall();
    logic [2:0] sels [4];
    sels = '{3'd5, 3'd1, 3'd2, 3'd3};
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1;
      in_sel = sels[t];
      step();
    end
    total++;
    if ({out_valid, out_data, out_sel} !== {1'b1, 8'h15, 3'd5}) begin
      bad++;
      $display("FAIL stall_head got v=%b d=%h s=%0d exp v=1 d=15 s=5", out_valid, out_data, out_sel);
    end
    out_ready = 1'b0;
    in_sel = sels[3];
    for (int t = 0; t < 4; t++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_ready t=%0d got %b exp 0", t, in_ready);
      end
      step();
      total++;
      if ({out_valid, out_data, out_sel} !== {1'b1, 8'h15, 3'd5}) begin
        bad++;
        $display("FAIL stall_hold t=%0d got v=%b d=%h s=%0d exp v=1 d=15 s=5",
                 t, out_valid, out_data, out_sel);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release_ready got %b exp 1", in_ready);
    end
    for (int t = 1; t < 5; t++) begin
      step();
      in_valid = 1'b0;
      total++;
      if (t < 4) begin
        if ({out_valid, out_data, out_sel} !== {1'b1, 8'(8'h10 + sels[t]), sels[t]}) begin
          bad++;
          $display("FAIL stall_drain t=%0d got v=%b d=%h s=%0d exp v=1 d=%h s=%0d",
                   t, out_valid, out_data, out_sel, 8'(8'h10 + sels[t]), sels[t]);
        end
      end else if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL stall_drain_end got v=%b exp v=0", out_valid);
      end
    end
    flush();
  endtask

  task automatic test_bubbles();
    logic [3:0] vpat;
    logic [2:0] sels [4];
    logic [7:0] exp_d [4];
    vpat = 4'b0101;
    sels = '{3'd2, 3'd7, 3'd6, 3'd0};
    exp_d = '{8'h12, 8'h00, 8'h16, 8'h00};
    for (int t = 0; t < 6; t++) begin
      in_valid = (t < 4) ? vpat[t] : 1'b0;
      in_sel = (t < 4) ? sels[t] : 3'd0;
      step();
      if (t >= 2) begin
        total++;
        if (out_valid !== vpat[t-2] || (vpat[t-2] && out_data !== exp_d[t-2])) begin
          bad++;
          $display("FAIL bubble t=%0d got v=%b d=%h exp v=%b d=%h",
                   t, out_valid, out_data, vpat[t-2], exp_d[t-2]);
        end
      end
    end
    flush();
  endtask

  task automatic test_reset_midstream();
    logic [2:0] sels [3];
    sels = '{3'd1, 3'd2, 3'd4};
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1;
      in_sel = sels[t];
      step();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_data, out_sel, in_ready} !== {1'b0, 8'h00, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL async_reset got v=%b d=%h s=%0d r=%b exp v=0 d=00 s=0 r=1",
               out_valid, out_data, out_sel, in_ready);
    end
    step();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_sel = 3'd3;
    for (int t = 0; t < 5; t++) begin
      step();
      in_valid = 1'b0;
      total++;
      if (t == 2) begin
        if ({out_valid, out_data, out_sel} !== {1'b1, 8'h13, 3'd3}) begin
          bad++;
          $display("FAIL post_reset_beat got v=%b d=%h s=%0d exp v=1 d=13 s=3",
                   out_valid, out_data, out_sel);
        end
      end else if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_stale t=%0d got v=%b exp v=0", t, out_valid);
      end
    end
    flush();
  endtask

  task automatic test_n2();
    for (int t = 0; t < 3; t++) begin
      in_valid2 = (t < 2);
      in_sel2 = 1'(t);
      step();
      total++;
      if (t < 2) begin
        if ({out_valid2, out_data2, out_sel2} !== {1'b1, 1'(t), 1'(t)}) begin
          bad++;
          $display("FAIL n2_beat t=%0d got v=%b d=%b s=%b exp v=1 d=%0d s=%0d",
                   t, out_valid2, out_data2, out_sel2, t, t);
        end
      end else if (out_valid2 !== 1'b0) begin
        bad++;
        $display("FAIL n2_idle got v=%b exp v=0", out_valid2);
      end
    end
    in_valid2 = 1'b0;
  endtask

`ifdef MUX_SCAN_EN
  task automatic test_scan();
    logic [2:0] exp_s;
    for (int t = 0; t < 13; t++) begin
      scan_en = (t < 10);
      in_valid = (t < 11);
      in_sel = (t == 10) ? 3'd4 : 3'd1;
      step();
      if (t >= 2) begin
        exp_s = (t - 2 < 10) ? 3'((t - 2) % 8) : 3'd4;
        total++;
        if ({out_valid, out_sel, out_data} !== {1'b1, exp_s, 8'(8'h10 + exp_s)}) begin
          bad++;
          $display("FAIL scan t=%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                   t, out_valid, out_sel, out_data, exp_s, 8'(8'h10 + exp_s));
        end
      end
    end
    scan_en = 1'b0;
    flush();
  endtask
`endif

  initial begin
    for (int k = 0; k < 8; k++) begin
      in_data[k*8 +: 8] = 8'(8'h10 + k);
    end
    test_reset();
    test_back_to_back();
    test_stall();
    test_bubbles();
    test_reset_midstream();
    test_n2();
`ifdef MUX_SCAN_EN
    test_scan();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
